// File: rtl/fetch_pkg.sv
// Shared types and constants for the per-hart instruction fetch queue.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] PC_STEP          = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  addr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instruction/address pairs with a one-cycle flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   flush,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Flush wins over push/pop; callers never pop an empty or push a full FIFO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Per-hart fetch stage: sequential word fetch, response buffering and branch redirect with stale-drop.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   imem_req_valid,
    input  logic                   imem_req_ready,
    output logic [31:0]            imem_req_addr,
    input  logic                   imem_resp_valid,
    input  logic [31:0]            imem_resp_data,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_addr,
    output logic                   cmd_valid,
    output logic [31:0]            cmd,
    output logic [31:0]            cmd_addr,
    input  logic                   cmd_take,
    output logic [$clog2(DEPTH):0] occupancy
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Headroom so back-to-back redirects can accumulate several rounds of stale responses.
    localparam int DW = CW + 4;

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [DW-1:0]     drop_cnt;
    logic [CW:0]       credits_used;
    logic              accept;
    logic              resp_drop;
    logic              push;
    logic              pop;
    fetch_entry_t      push_data;
    fetch_entry_t      head;

    assign credits_used   = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = reset & ~redirect_valid & (credits_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign accept         = imem_req_valid & imem_req_ready;

    assign resp_drop = imem_resp_valid & (drop_cnt != '0);
    assign push      = imem_resp_valid & (drop_cnt == '0) & ~redirect_valid;

    assign cmd_valid = (count != '0) & ~redirect_valid;
    assign pop       = cmd_valid & cmd_take;

    assign push_data.instr = imem_resp_data;
    assign push_data.addr  = resp_pc;

    // Any response seen during a redirect is stale, whether it was already counted as a drop or still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc       <= RESET_PC;
            resp_pc  <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            pc       <= word_align(redirect_addr);
            resp_pc  <= word_align(redirect_addr);
            inflight <= '0;
            drop_cnt <= drop_cnt + DW'(inflight) - DW'(imem_resp_valid);
        end else begin
            if (accept) begin
                pc <= pc + PC_STEP;
            end
            if (push) begin
                resp_pc <= resp_pc + PC_STEP;
            end
            if (resp_drop) begin
                drop_cnt <= drop_cnt - DW'(1);
            end
            case ({accept, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign cmd       = head.instr;
    assign cmd_addr  = head.addr;
    assign occupancy = count;

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Per-hart instruction fetch stage, one instance per hart, sitting directly upstream of the two-input command arbiter.
- Holds the hart PC and issues sequential word fetches to instruction memory.
- Buffers returned instructions together with their addresses in a small FIFO and presents them as command / command-valid / address.
- Branch redirect flushes the queue, drops in-flight responses and restarts fetch at the target.

Parameters:
- DEPTH, 4, FIFO entries and maximum outstanding requests combined (power of 2, ≥2).
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address (word aligned).
- imem_resp_valid  in  1  instruction word returned; in-order, never earlier than the cycle after accept.
- imem_resp_data  in  32  returned instruction.
- redirect_valid  in  1  branch redirect pulse.
- redirect_addr  in  32  redirect target; bits [1:0] are ignored and treated as 0.
- cmd_valid  out  1  head entry valid (feeds the arbiter valid input).
- cmd  out  32  head instruction.
- cmd_addr  out  32  head instruction address.
- cmd_take  in  1  arbiter consumed the head this cycle.
- occupancy  out  $clog2(DEPTH)+1  FIFO entry count.

Behaviour:
- Reset values (async, reset=0):
  - pc=RESET_PC, resp_pc=RESET_PC.
  - count=0, inflight=0, drop_cnt=0.
  - cmd_valid=0, imem_req_valid=0, cmd=0, cmd_addr=0, occupancy=0.
  - Reset mid-transfer discards everything; any memory response arriving afterwards while drop_cnt=0 is treated as new data. The memory side must be reset together with this block.
- Request side:
  - imem_req_valid = reset deasserted & ~redirect_valid & (count+inflight < DEPTH).
  - imem_req_addr = pc.
  - On accept (valid & ready): pc += 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0) and inflight += 1.
  - The credit rule guarantees the FIFO can never overflow.
- Response side, on imem_resp_valid:
  - If drop_cnt≠0: discard the word, drop_cnt -= 1.
  - Otherwise: push {imem_resp_data, resp_pc} into the FIFO, resp_pc += 4, inflight -= 1.
  - An accept and a retire in the same cycle leave inflight unchanged.
- Output side:
  - cmd_valid = (count≠0) & ~redirect_valid.
  - cmd/cmd_addr show the FIFO head; they hold stable while cmd_valid=1 and no take occurs.
  - Latency: response at cycle N with an empty FIFO gives cmd_valid=1 at cycle N+1.
  - cmd_take with cmd_valid=0 is ignored.
  - Push and pop in the same cycle leave count unchanged.
- Redirect (has priority over everything in that cycle):
  - pc and resp_pc are set to {redirect_addr[31:2],2'b00}.
  - count is set to 0.
  - drop_cnt is set to drop_cnt + inflight − (1 if a droppable response arrives this cycle, else 0).
  - inflight is set to 0.
  - No request is issued and cmd_take is ignored this cycle.
  - A redirect during a non-empty drop phase accumulates onto drop_cnt.
  - The first fetch from the target is issued the cycle after the redirect.
- occupancy = count (registered).

Decomposition:
- Shared package fetch_pkg:
  - INSTR_W=32, ADDR_W=32, PC_STEP=4.
  - Typedef fetch_entry_t {instr, addr}.
  - Constant RESET_PC_DEFAULT.
- One sub-module: fetch_fifo. Synchronous FIFO of fetch_entry_t with:
  - inputs: push, pop, flush;
  - outputs: head, count;
  - async active-low reset.
- Control logic (credits, drop counter, pc/resp_pc) lives in the top module.

Test Plan:
1. Reset release, imem_req_ready=1, response 1 cycle after each accept, cmd_take=0:
   - requests at addresses 0,4,8,12, then imem_req_valid=0 (count+inflight=4).
   - cmd_valid=1 with cmd_addr=0; occupancy reaches 4.
2. Same as 1, then cmd_take held high:
   - cmd_addr sequence 0,4,8,… with no gaps after steady state.
   - FIFO never exceeds 4 entries.
3. Two requests in flight (addresses 0x10, 0x14), then redirect_valid with redirect_addr=0x103:
   - next request address is 0x100.
   - both stale responses are dropped.
   - first cmd_addr after the redirect is 0x100.
4. Redirect asserted in the same cycle as a stale response and cmd_take:
   - count=0 the next cycle, drop_cnt = inflight−1.
   - cmd_valid=0 during the redirect cycle.
5. RESET_PC=32'hFFFF_FFF8:
   - fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000; cmd_addr matches each.
6. Assert reset with FIFO at 3 entries and 1 request in flight:
   - all outputs zero immediately (async).
   - after release, first request goes to RESET_PC.
